// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 encodings, master state enum and response merge
//
// Contents:
//   BURST_*         AXI4 burst type encodings (FIXED/INCR/WRAP, plus the reserved code)
//   RESP_*          AXI4 response encodings (OKAY/EXOKAY/SLVERR/DECERR)
//   master_state_t  command master FSM states
//   resp_merge      folds two responses, keeping the more severe (numerically larger)
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_WRESP = 3'd5,
        ST_DONE  = 3'd6
    } master_state_t;

    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_beat_cnt.sv
// rtl/axi4_beat_cnt.sv - burst beat counter shared by the read and write data paths
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clr        restart the count at zero (new command)
//   inc        one data beat handshaked this cycle
//   last_idx   index of the final beat (axlen)
//   count      current beat index
//   is_last    count has reached last_idx
module axi4_beat_cnt #(
    parameter int LEN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic [LEN_BITS-1:0] last_idx,
    output logic [LEN_BITS-1:0] count,
    output logic                is_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + LEN_BITS'(1);
        end
    end

    assign is_last = (count == last_idx);

endmodule

// File: rtl/axi4_cmd_master.sv
// rtl/axi4_cmd_master.sv - AXI4 initiator turning one command into one burst transaction
//
// Optional watchdog: define AXI4_CMD_MASTER_TIMEOUT_EN to abort a stalled transaction
// after TIMEOUT_CYCLES cycles with no handshake (done_resp = DECERR).
//
// Ports:
//   PCLK, PRESET                       clock, asynchronous active-high reset
//   cmd_*                              command handshake and fields (write, addr, len, size, burst)
//   wr_data/wr_strb/wr_valid/wr_ready  write beat stream in
//   rd_data/rd_last/rd_valid/rd_ready  read beat stream out
//   done_valid/done_resp               one-cycle completion pulse with final response
//   ar*/r*/aw*/w*/b*                   AXI4 master channels
module axi4_cmd_master
    import axi4_pkg::*;
#(
    parameter int ADDR_BITS      = 32,
    parameter int DATA_BITS      = 32,
    parameter int LOGSIZE_BITS   = 3,
    parameter int LEN_BITS       = 8,
    parameter int BURST_BITS     = 2,
    parameter int RESP_BITS      = 2,
    parameter int WSTRB_BITS     = DATA_BITS / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [LEN_BITS-1:0]     cmd_len,
    input  logic [LOGSIZE_BITS-1:0] cmd_size,
    input  logic [BURST_BITS-1:0]   cmd_burst,

    input  logic [DATA_BITS-1:0]    wr_data,
    input  logic [WSTRB_BITS-1:0]   wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,

    output logic [DATA_BITS-1:0]    rd_data,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,

    output logic                    done_valid,
    output logic [RESP_BITS-1:0]    done_resp,

    output logic [ADDR_BITS-1:0]    araddr,
    output logic [LEN_BITS-1:0]     arlen,
    output logic [LOGSIZE_BITS-1:0] arsize,
    output logic [BURST_BITS-1:0]   arburst,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [DATA_BITS-1:0]    rdata,
    input  logic [RESP_BITS-1:0]    rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,

    output logic [ADDR_BITS-1:0]    awaddr,
    output logic [LEN_BITS-1:0]     awlen,
    output logic [LOGSIZE_BITS-1:0] awsize,
    output logic [BURST_BITS-1:0]   awburst,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_BITS-1:0]    wdata,
    output logic [WSTRB_BITS-1:0]   wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [RESP_BITS-1:0]    bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int MAX_SIZE = $clog2(WSTRB_BITS);

    master_state_t         state;
    master_state_t         state_next;
    logic [LEN_BITS-1:0]   len_q;
    logic [RESP_BITS-1:0]  acc;
    logic [LEN_BITS-1:0]   beat_count;
    logic                  beat_is_last;

    logic cmd_fire;
    logic cmd_illegal;
    logic ar_fire;
    logic aw_fire;
    logic r_fire;
    logic w_fire;
    logic b_fire;
    logic timeout;

    assign cmd_ready = (state == ST_IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;

    // WRAP bursts must be 2, 4, 8 or 16 beats; the reserved burst code and
    // beats wider than the bus are rejected without touching the bus.
    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_size > LOGSIZE_BITS'(MAX_SIZE)) begin
            cmd_illegal = 1'b1;
        end
        if (cmd_burst == BURST_BITS'(BURST_RSVD)) begin
            cmd_illegal = 1'b1;
        end
        if ((cmd_burst == BURST_BITS'(BURST_WRAP)) &&
            !((cmd_len == LEN_BITS'(1)) || (cmd_len == LEN_BITS'(3)) ||
              (cmd_len == LEN_BITS'(7)) || (cmd_len == LEN_BITS'(15)))) begin
            cmd_illegal = 1'b1;
        end
    end

    // Handshakes are derived from state and inputs, not from the driven
    // outputs, so the watchdog can steer the FSM without a combinational loop.
    assign ar_fire = (state == ST_RADDR) & arready;
    assign aw_fire = (state == ST_WADDR) & awready;
    assign r_fire  = (state == ST_RDATA) & rvalid & rd_ready;
    assign w_fire  = (state == ST_WDATA) & wr_valid & wready;
    assign b_fire  = (state == ST_WRESP) & bvalid;

`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_BITS-1:0] wd_count;
    logic               wd_active;
    logic               any_fire;

    assign wd_active = (state == ST_RADDR) || (state == ST_RDATA) || (state == ST_WADDR) ||
                       (state == ST_WDATA) || (state == ST_WRESP);
    assign any_fire  = ar_fire | aw_fire | r_fire | w_fire | b_fire;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wd_count <= '0;
        end else if (!wd_active || any_fire) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + WD_BITS'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; DONE follows next.
    assign timeout = wd_active && !any_fire && (wd_count == WD_BITS'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    axi4_beat_cnt #(
        .LEN_BITS (LEN_BITS)
    ) u_beat_cnt (
        .clk      (PCLK),
        .rst      (PRESET),
        .clr      (cmd_fire),
        .inc      (r_fire | w_fire),
        .last_idx (len_q),
        .count    (beat_count),
        .is_last  (beat_is_last)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        awvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        wr_ready   = 1'b0;
        bready     = 1'b0;
        done_valid = 1'b0;
        done_resp  = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal) begin
                        state_next = ST_DONE;
                    end else if (cmd_write) begin
                        state_next = ST_WADDR;
                    end else begin
                        state_next = ST_RADDR;
                    end
                end
            end
            ST_RADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = ST_RDATA;
                end
            end
            ST_RDATA: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = rlast;
                if (r_fire && rlast) begin
                    state_next = ST_DONE;
                end
            end
            ST_WADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_next = ST_WDATA;
                end
            end
            ST_WDATA: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = wr_valid & beat_is_last;
                if (w_fire && beat_is_last) begin
                    state_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_resp  = acc;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (timeout) begin
            state_next = ST_DONE;
        end
    end

    assign rd_data = rdata;
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arburst <= '0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            awburst <= '0;
            len_q   <= '0;
            acc     <= RESP_OKAY;
        end else begin
            if (cmd_fire) begin
                len_q <= cmd_len;
                acc   <= cmd_illegal ? RESP_SLVERR : RESP_OKAY;
                if (!cmd_illegal && cmd_write) begin
                    awaddr  <= cmd_addr;
                    awlen   <= cmd_len;
                    awsize  <= cmd_size;
                    awburst <= cmd_burst;
                end
                if (!cmd_illegal && !cmd_write) begin
                    araddr  <= cmd_addr;
                    arlen   <= cmd_len;
                    arsize  <= cmd_size;
                    arburst <= cmd_burst;
                end
            end
            // An rlast that disagrees with the beat count marks the burst as
            // a slave error; the transfer still runs until rlast is seen.
            if (r_fire) begin
                acc <= (rlast != beat_is_last) ? RESP_SLVERR : resp_merge(acc, rresp);
            end
            if (b_fire) begin
                acc <= resp_merge(acc, bresp);
            end
            if (timeout) begin
                acc <= RESP_DECERR;
            end
        end
    end

endmodule

// File: tb/tb_axi4_cmd_master.sv
// tb/tb_axi4_cmd_master.sv - self-checking bench for axi4_cmd_master
module tb_axi4_cmd_master;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, awvalid, awready;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;

    logic [31:0] sent_data[$];
    logic [3:0]  sent_strb[$];
    logic [1:0]  sent_resp[$];
    logic        sent_last[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_strb[$];
    logic        got_last[$];

    bit          done_seen, done_next_obs, ready_at_done, bready_at_done;
    bit          ar_seen, aw_seen, addr_unstable, w_before_aw, wrong_side;
    int          done_cyc, wresp_start, addr_valid_cycles;
    logic [1:0]  done_resp_obs;
    logic [31:0] obs_addr;
    logic [7:0]  obs_len;
    logic [2:0]  obs_size;
    logic [1:0]  obs_burst;

    always #5 PCLK = ~PCLK;

    axi4_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_resp(done_resp),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic slave_quiet();
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    endtask

    task automatic issue_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [1:0] b);
        int w;
        w = 0;
        sent_data.delete(); sent_strb.delete(); sent_resp.delete(); sent_last.delete();
        got_data.delete(); got_strb.delete(); got_last.delete();
        done_seen = 0; done_next_obs = 0; ready_at_done = 0; bready_at_done = 0;
        ar_seen = 0; aw_seen = 0; addr_unstable = 0; w_before_aw = 0; wrong_side = 0;
        done_cyc = -1; wresp_start = -1; addr_valid_cycles = 0; done_resp_obs = '0;
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
        cmd_valid = 1;
        #1;
        while (!cmd_ready && w < 20) begin
            @(negedge PCLK); #1; w++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL cmd_accept: cmd_ready=%0b want 1", cmd_ready);
        end
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 0;
    endtask

    task automatic note_addr(input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [1:0] b);
        if (addr_valid_cycles == 0) begin
            obs_addr = a; obs_len = l; obs_size = s; obs_burst = b;
        end else if ({a, l, s, b} !== {obs_addr, obs_len, obs_size, obs_burst}) begin
            addr_unstable = 1;
        end
        addr_valid_cycles++;
    endtask

    // Slave side of a read: answers AR after ar_delay cycles, then sends beats
    // until the one carrying rlast (beat number rlast_beat, 1-based).
    task automatic run_read(input int rlast_beat, input int ar_delay, input bit stall,
                            input bit rand_resp, input int budget);
        int beats, ar_wait;
        bit ar_done;
        logic [31:0] cur_d;
        logic [1:0]  cur_r;
        beats = 0; ar_wait = 0; ar_done = 0;
        cur_d = $urandom; cur_r = rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
        for (int cyc = 0; cyc < budget; cyc++) begin
            arready = arvalid && (ar_wait >= ar_delay);
            rvalid = ar_done && (beats < rlast_beat) && (!stall || $urandom_range(0, 2) != 0);
            rdata = cur_d; rresp = cur_r; rlast = (beats + 1 == rlast_beat);
            rd_ready = !stall || ($urandom_range(0, 3) != 0);
            #1;
            if (awvalid || wvalid || bready) wrong_side = 1;
            if (done_valid) begin
                done_seen = 1; done_resp_obs = done_resp; done_cyc = cyc;
                ready_at_done = cmd_ready; bready_at_done = bready;
                break;
            end
            if (arvalid) begin
                ar_seen = 1; ar_wait++;
                note_addr(araddr, arlen, arsize, arburst);
                if (arready) ar_done = 1;
            end
            if (rd_valid && rd_ready) begin
                got_data.push_back(rd_data); got_last.push_back(rd_last);
                sent_data.push_back(cur_d); sent_resp.push_back(cur_r); sent_last.push_back(rlast);
                beats++;
                cur_d = $urandom; cur_r = rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
            end
            @(negedge PCLK);
        end
        slave_quiet();
        if (done_seen) begin
            @(negedge PCLK); #1; done_next_obs = done_valid;
        end
    endtask

    // Slave side of a write plus the front-end data stream. b_delay < 0 means
    // the slave never responds; stop_after > 0 returns right after that many beats.
    task automatic run_write(input int len, input int aw_delay, input bit stall,
                             input int b_delay, input logic [1:0] b_resp,
                             input int budget, input int stop_after);
        int wbeats, aw_wait, b_wait;
        bit aw_done, w_done;
        logic [31:0] cur_d;
        logic [3:0]  cur_s;
        wbeats = 0; aw_wait = 0; b_wait = 0; aw_done = 0; w_done = 0;
        cur_d = $urandom; cur_s = 4'($urandom);
        for (int cyc = 0; cyc < budget; cyc++) begin
            awready = awvalid && (aw_wait >= aw_delay);
            wr_valid = (wbeats <= len) && (!stall || $urandom_range(0, 3) != 0);
            wr_data = cur_d; wr_strb = cur_s;
            wready = !stall || ($urandom_range(0, 3) != 0);
            bvalid = w_done && (b_delay >= 0) && (b_wait >= b_delay);
            bresp = b_resp;
            #1;
            if (arvalid || rready || rd_valid) wrong_side = 1;
            if (done_valid) begin
                done_seen = 1; done_resp_obs = done_resp; done_cyc = cyc;
                ready_at_done = cmd_ready; bready_at_done = bready;
                break;
            end
            if (bready && wresp_start < 0) wresp_start = cyc;
            if (bready) b_wait++;
            if (wvalid && !aw_done) w_before_aw = 1;
            if (awvalid) begin
                aw_seen = 1; aw_wait++;
                note_addr(awaddr, awlen, awsize, awburst);
                if (awready) aw_done = 1;
            end
            if (wvalid && wready) begin
                got_data.push_back(wdata); got_strb.push_back(wstrb); got_last.push_back(wlast);
                sent_data.push_back(cur_d); sent_strb.push_back(cur_s);
                wbeats++;
                cur_d = $urandom; cur_s = 4'($urandom);
                if (wbeats == len + 1) w_done = 1;
                if (stop_after > 0 && wbeats == stop_after) begin
                    @(posedge PCLK); #1;
                    return;
                end
            end
            @(negedge PCLK);
        end
        slave_quiet();
        if (done_seen) begin
            @(negedge PCLK); #1; done_next_obs = done_valid;
        end
    endtask

    task automatic test_reset();
        slave_quiet();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        PRESET = 1;
        repeat (3) @(negedge PCLK);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready);
        end
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, done_valid, done_resp} !== 8'h00) begin
            failures++;
            $display("FAIL reset_handshakes: got %b want 00000000",
                     {arvalid, awvalid, wvalid, rready, bready, done_valid, done_resp});
        end
        checks++;
        if ({araddr, arlen, arsize, arburst, awaddr, awlen, awsize, awburst} !== '0) begin
            failures++; $display("FAIL reset_ax_regs: got araddr=%0h awaddr=%0h want 0", araddr, awaddr);
        end
        @(negedge PCLK);
        PRESET = 0;
        @(negedge PCLK);
    endtask

    task automatic test_read_incr();
        bit bad;
        issue_cmd(0, 32'h10, 8'd3, 3'd2, 2'b01);
        run_read(4, 0, 0, 0, 100);
        checks++;
        if (!done_seen || obs_addr !== 32'h10 || obs_len !== 8'd3 || obs_size !== 3'd2 || obs_burst !== 2'b01) begin
            failures++;
            $display("FAIL read_incr_ar: done=%0b araddr=%0h arlen=%0d want done=1 araddr=10 arlen=3",
                     done_seen, obs_addr, obs_len);
        end
        bad = (got_data.size() != 4);
        for (int i = 0; i < got_data.size() && !bad; i++)
            if (got_data[i] !== sent_data[i] || got_last[i] !== (i == 3)) bad = 1;
        checks++;
        if (bad) begin
            failures++; $display("FAIL read_incr_beats: got %0d beats (or data/last differ) want 4", got_data.size());
        end
        checks++;
        if (done_resp_obs !== 2'b00 || done_next_obs !== 1'b0 || ready_at_done !== 1'b0) begin
            failures++;
            $display("FAIL read_incr_done: resp=%b next=%0b ready=%0b want resp=00 next=0 ready=0",
                     done_resp_obs, done_next_obs, ready_at_done);
        end
        issue_cmd(0, 32'h44, 8'd0, 3'd2, 2'b01);
        run_read(1, 0, 0, 0, 50);
        checks++;
        if (done_cyc !== 2 || done_resp_obs !== 2'b00) begin
            failures++; $display("FAIL read_latency: done at cycle %0d resp=%b want 2 resp=00", done_cyc, done_resp_obs);
        end
    endtask

    task automatic test_write_delayed_aw();
        bit bad;
        issue_cmd(1, 32'h200, 8'd1, 3'd2, 2'b01);
        run_write(1, 5, 0, 0, 2'b00, 100, 0);
        checks++;
        if (addr_valid_cycles !== 6 || addr_unstable || obs_addr !== 32'h200 || obs_len !== 8'd1) begin
            failures++;
            $display("FAIL write_aw_hold: cycles=%0d unstable=%0b awaddr=%0h want 6 0 200",
                     addr_valid_cycles, addr_unstable, obs_addr);
        end
        checks++;
        if (w_before_aw) begin
            failures++; $display("FAIL write_w_order: wvalid before AW got 1 want 0");
        end
        bad = (got_data.size() != 2);
        for (int i = 0; i < got_data.size() && !bad; i++)
            if (got_data[i] !== sent_data[i] || got_strb[i] !== sent_strb[i] || got_last[i] !== (i == 1)) bad = 1;
        checks++;
        if (bad) begin
            failures++; $display("FAIL write_beats: got %0d beats (or data/wlast differ) want 2", got_data.size());
        end
        checks++;
        if (!done_seen || done_resp_obs !== 2'b00) begin
            failures++; $display("FAIL write_done: done=%0b resp=%b want 1 00", done_seen, done_resp_obs);
        end
    endtask

    task automatic test_rlast_mismatch();
        issue_cmd(0, 32'h80, 8'd2, 3'd2, 2'b01);
        run_read(2, 1, 0, 0, 100);
        checks++;
        if (!done_seen || done_resp_obs !== 2'b10 || got_data.size() != 2) begin
            failures++;
            $display("FAIL early_rlast: done=%0b resp=%b beats=%0d want 1 10 2", done_seen, done_resp_obs, got_data.size());
        end
        issue_cmd(0, 32'h90, 8'd2, 3'd2, 2'b01);
        run_read(4, 0, 0, 0, 100);
        checks++;
        if (!done_seen || done_resp_obs !== 2'b10 || got_data.size() != 4) begin
            failures++;
            $display("FAIL late_rlast: done=%0b resp=%b beats=%0d want 1 10 4", done_seen, done_resp_obs, got_data.size());
        end
    endtask

    task automatic test_illegal();
        logic [2:0] sz[3];
        logic [1:0] bu[3];
        logic [7:0] ln[3];
        sz[0] = 3'd3; bu[0] = 2'b01; ln[0] = 8'd0;
        sz[1] = 3'd2; bu[1] = 2'b11; ln[1] = 8'd1;
        sz[2] = 3'd2; bu[2] = 2'b10; ln[2] = 8'd2;
        for (int k = 0; k < 6; k++) begin
            issue_cmd(k[0], 32'h1000, ln[k/2], sz[k/2], bu[k/2]);
            if (k[0]) run_write(int'(ln[k/2]), 0, 0, 0, 2'b00, 30, 0);
            else      run_read(int'(ln[k/2]) + 1, 0, 0, 0, 30);
            checks++;
            if (!done_seen || done_cyc !== 0 || ar_seen || aw_seen || done_resp_obs !== 2'b10) begin
                failures++;
                $display("FAIL illegal_%0d: done=%0b cyc=%0d ar=%0b aw=%0b resp=%b want 1 0 0 0 10",
                         k, done_seen, done_cyc, ar_seen, aw_seen, done_resp_obs);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        issue_cmd(1, 32'h300, 8'd3, 3'd2, 2'b01);
        run_write(3, 0, 0, 0, 2'b00, 50, 1);
        PRESET = 1;
        #1;
        checks++;
        if (wvalid !== 1'b0 || cmd_ready !== 1'b1 || awvalid !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write: wvalid=%0b cmd_ready=%0b want 0 1", wvalid, cmd_ready);
        end
        @(negedge PCLK);
        slave_quiet();
        PRESET = 0;
        @(negedge PCLK);
        issue_cmd(0, 32'h400, 8'd1, 3'd2, 2'b01);
        run_read(2, 0, 0, 0, 50);
        checks++;
        if (!done_seen || done_resp_obs !== 2'b00 || got_data.size() != 2 || obs_addr !== 32'h400) begin
            failures++;
            $display("FAIL read_after_reset: done=%0b resp=%b beats=%0d want 1 00 2", done_seen, done_resp_obs, got_data.size());
        end
    endtask

    task automatic test_timeout();
        issue_cmd(1, 32'h500, 8'd0, 3'd2, 2'b01);
`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
        run_write(0, 0, 0, -1, 2'b00, 100, 0);
        checks++;
        if (!done_seen || done_resp_obs !== 2'b11 || (done_cyc - wresp_start) !== TO || bready_at_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout: done=%0b resp=%b after %0d cycles bready=%0b want 1 11 %0d 0",
                     done_seen, done_resp_obs, done_cyc - wresp_start, bready_at_done, TO);
        end
`else
        run_write(0, 0, 0, -1, 2'b00, 1010, 0);
        #1;
        checks++;
        if (done_seen || bready !== 1'b1) begin
            failures++; $display("FAIL no_timeout_wait: done=%0b bready=%0b want 0 1", done_seen, bready);
        end
        bvalid = 1; bresp = 2'b01;
        @(posedge PCLK);
        @(negedge PCLK);
        bvalid = 0; bresp = 2'b00;
        #1;
        checks++;
        if (done_valid !== 1'b1 || done_resp !== 2'b01) begin
            failures++; $display("FAIL late_bresp: done_valid=%0b resp=%b want 1 01", done_valid, done_resp);
        end
        @(negedge PCLK);
`endif
    endtask

    task automatic test_back_to_back();
        bit wr, legal, stall, bad;
        logic [7:0] l;
        logic [2:0] s;
        logic [1:0] b, br, exp;
        int r, rl;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            l = 8'($urandom_range(0, 7));
            s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r == 0) b = 2'b11;
            else if (r <= 3) begin
                b = 2'b10;
                if (r != 3) l = 8'((1 << $urandom_range(1, 4)) - 1);
            end else b = 2'($urandom_range(0, 1));
            legal = (s <= 3'd2) && (b != 2'b11) &&
                    !(b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
            br = 2'($urandom_range(0, 3));
            issue_cmd(wr, $urandom, l, s, b);
            if (wr) begin
                run_write(int'(l), $urandom_range(0, 4), stall, $urandom_range(0, 3), br, 400, 0);
            end else begin
                rl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(l) + 2) : int'(l) + 1;
                run_read(rl, $urandom_range(0, 4), stall, 1, 400);
            end
            checks++;
            if (!done_seen || done_next_obs || ready_at_done || wrong_side) begin
                failures++;
                $display("FAIL b2b_%0d_done: seen=%0b next=%0b ready=%0b cross=%0b want 1 0 0 0",
                         n, done_seen, done_next_obs, ready_at_done, wrong_side);
            end
            if (!legal) begin
                checks++;
                if (done_cyc !== 0 || ar_seen || aw_seen || done_resp_obs !== 2'b10) begin
                    failures++;
                    $display("FAIL b2b_%0d_illegal: cyc=%0d ar=%0b aw=%0b resp=%b want 0 0 0 10",
                             n, done_cyc, ar_seen, aw_seen, done_resp_obs);
                end
            end else begin
                checks++;
                if ({obs_addr, obs_len, obs_size, obs_burst} !== {cmd_addr, l, s, b} || addr_unstable) begin
                    failures++;
                    $display("FAIL b2b_%0d_addr: addr=%0h len=%0d unstable=%0b want %0h %0d 0",
                             n, obs_addr, obs_len, addr_unstable, cmd_addr, l);
                end
                exp = 2'b00;
                bad = 0;
                if (wr) begin
                    exp = br;
                    bad = (got_data.size() != int'(l) + 1);
                    for (int i = 0; i < got_data.size(); i++)
                        if (got_data[i] !== sent_data[i] || got_strb[i] !== sent_strb[i] ||
                            got_last[i] !== (i == int'(l))) bad = 1;
                end else begin
                    bad = (got_data.size() != rl);
                    for (int i = 0; i < got_data.size(); i++) begin
                        if (got_data[i] !== sent_data[i] || got_last[i] !== sent_last[i]) bad = 1;
                        if (sent_last[i] != (i == int'(l))) exp = 2'b10;
                        else if (sent_resp[i] > exp) exp = sent_resp[i];
                    end
                end
                checks++;
                if (bad) begin
                    failures++; $display("FAIL b2b_%0d_beats: got %0d beats with a data/last difference", n, got_data.size());
                end
                checks++;
                if (done_resp_obs !== exp) begin
                    failures++; $display("FAIL b2b_%0d_resp: got %b want %b", n, done_resp_obs, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_incr();
        test_write_delayed_aw();
        test_rlast_mismatch();
        test_illegal();
        test_reset_mid_write();
        test_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
